// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package ssd_pkg;

  localparam int         SSD_NUM_DIGITS = 8;
  localparam logic [4:0] SSD_BLANK_CODE = 5'h1F;

  typedef struct packed {
    logic [4:0] code;
    logic       dp;
  } ssd_entry_t;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } ssd_state_t;

  localparam ssd_entry_t SSD_RESET_ENTRY = ssd_entry_t'({SSD_BLANK_CODE, 1'b1});

  // Active-low anode pattern selecting a single digit.
  function automatic logic [7:0] ssd_anode(input logic [2:0] idx);
    logic [7:0] one_hot;
    one_hot = 8'h01 << idx;
    return ~one_hot;
  endfunction

endpackage

// File: rtl/ssd_lz_mask.sv
// Leading-zero blank mask: digit i (i >= 1) is blanked when it and every
// more significant digit hold code zero. Digit 0 is never blanked.
module ssd_lz_mask
  import ssd_pkg::*;
(
  input  logic [SSD_NUM_DIGITS-1:0][4:0] codes,
  output logic [SSD_NUM_DIGITS-1:0]      mask
);

  logic run_s;

  // Walk from the most significant digit down while codes stay zero.
  always_comb begin
    run_s = 1'b1;
    mask  = {SSD_NUM_DIGITS{1'b0}};
    for (int i = SSD_NUM_DIGITS - 1; i >= 1; i--) begin
      run_s   = run_s && (codes[i] == 5'h00);
      mask[i] = run_s;
    end
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Time-multiplexed 8-digit scan controller with a double-buffered frame,
// frame-boundary commit, per-digit enable and leading-zero blanking.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2000
) (
  input  logic       ssd_scan_ctrl_port_clk,
  input  logic       ssd_scan_ctrl_port_rst,
  input  logic       ssd_scan_ctrl_port_wr_en,
  input  logic [2:0] ssd_scan_ctrl_port_wr_addr,
  input  logic [4:0] ssd_scan_ctrl_port_wr_code,
  input  logic       ssd_scan_ctrl_port_wr_dp,
  input  logic       ssd_scan_ctrl_port_commit,
  input  logic [7:0] ssd_scan_ctrl_port_digit_en,
  input  logic       ssd_scan_ctrl_port_blank_lz,
  output logic [4:0] ssd_scan_ctrl_port_code,
  output logic       ssd_scan_ctrl_port_dp,
  output logic [7:0] ssd_scan_ctrl_port_an,
  output logic       ssd_scan_ctrl_port_commit_ack,
  output logic       ssd_scan_ctrl_port_frame_done
);

  localparam int               CNT_W          = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO       = CNT_W'(0);

  ssd_state_t       state_r, state_s;
  logic [CNT_W-1:0] slot_cnt_r, slot_cnt_s;
  logic [2:0]       idx_r, idx_s;
  logic             pending_r;
  ssd_entry_t       shadow_r [SSD_NUM_DIGITS];
  ssd_entry_t       active_r [SSD_NUM_DIGITS];
  ssd_entry_t       active_s [SSD_NUM_DIGITS];
  logic             boundary_s, copy_s;
  logic [SSD_NUM_DIGITS-1:0][4:0] lz_codes_s;
  logic [SSD_NUM_DIGITS-1:0]      lz_mask_s;
  ssd_entry_t       cur_s;
  logic [4:0]       code_s;
  logic             dp_s;
  logic [7:0]       an_s;

  assign boundary_s = (state_r == DRIVE) && (slot_cnt_r == CNT_LAST) && (idx_r == 3'd7);
  assign copy_s     = boundary_s && (pending_r || ssd_scan_ctrl_port_commit);

  // Slot sequencing: blank interval, then drive until the slot ends.
  always_comb begin
    state_s    = state_r;
    slot_cnt_s = slot_cnt_r + CNT_ONE;
    idx_s      = idx_r;
    case (state_r)
      BLANK: begin
        if (slot_cnt_r == CNT_BLANK_LAST) state_s = DRIVE;
        else                              state_s = BLANK;
      end
      DRIVE: begin
        if (slot_cnt_r == CNT_LAST) begin
          state_s    = BLANK;
          slot_cnt_s = CNT_ZERO;
          idx_s      = idx_r + 3'd1;
        end else begin
          state_s = DRIVE;
        end
      end
      default: begin
        state_s    = BLANK;
        slot_cnt_s = CNT_ZERO;
        idx_s      = 3'd0;
      end
    endcase
  end

  // Outputs are registered from next-cycle state, so the bank being
  // committed at the boundary is already what the digit-0 slot presents.
  always_comb begin
    for (int i = 0; i < SSD_NUM_DIGITS; i++) begin
      if (copy_s) active_s[i] = shadow_r[i];
      else        active_s[i] = active_r[i];
      lz_codes_s[i] = active_s[i].code;
    end
  end

  ssd_lz_mask u_lz_mask (
    .codes (lz_codes_s),
    .mask  (lz_mask_s)
  );

  // Digit substitution: disabled digits go dark, blanked digits show blank glyph.
  always_comb begin
    cur_s  = active_s[idx_s];
    code_s = cur_s.code;
    dp_s   = cur_s.dp;
    an_s   = 8'hFF;
    if (!ssd_scan_ctrl_port_digit_en[idx_s]) begin
      code_s = SSD_BLANK_CODE;
    end else if (ssd_scan_ctrl_port_blank_lz && lz_mask_s[idx_s]) begin
      code_s = SSD_BLANK_CODE;
      dp_s   = 1'b1;
    end else begin
      code_s = cur_s.code;
    end
    if ((state_s == DRIVE) && ssd_scan_ctrl_port_digit_en[idx_s]) an_s = ssd_anode(idx_s);
    else                                                            an_s = 8'hFF;
  end

  // Scan state, counters and commit bookkeeping.
  always_ff @(posedge ssd_scan_ctrl_port_clk or posedge ssd_scan_ctrl_port_rst) begin
    if (ssd_scan_ctrl_port_rst) begin
      state_r    <= BLANK;
      slot_cnt_r <= CNT_ZERO;
      idx_r      <= 3'd0;
      pending_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      slot_cnt_r <= slot_cnt_s;
      idx_r      <= idx_s;
      if (boundary_s) pending_r <= 1'b0;
      else            pending_r <= pending_r | ssd_scan_ctrl_port_commit;
    end
  end

  // Shadow and active banks; the copy reads pre-edge shadow contents.
  always_ff @(posedge ssd_scan_ctrl_port_clk or posedge ssd_scan_ctrl_port_rst) begin
    if (ssd_scan_ctrl_port_rst) begin
      for (int i = 0; i < SSD_NUM_DIGITS; i++) begin
        shadow_r[i] <= SSD_RESET_ENTRY;
        active_r[i] <= SSD_RESET_ENTRY;
      end
    end else begin
      for (int i = 0; i < SSD_NUM_DIGITS; i++) begin
        active_r[i] <= active_s[i];
      end
      if (ssd_scan_ctrl_port_wr_en) begin
        shadow_r[ssd_scan_ctrl_port_wr_addr] <=
          ssd_entry_t'({ssd_scan_ctrl_port_wr_code, ssd_scan_ctrl_port_wr_dp});
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge ssd_scan_ctrl_port_clk or posedge ssd_scan_ctrl_port_rst) begin
    if (ssd_scan_ctrl_port_rst) begin
      ssd_scan_ctrl_port_code       <= SSD_BLANK_CODE;
      ssd_scan_ctrl_port_dp         <= 1'b1;
      ssd_scan_ctrl_port_an         <= 8'hFF;
      ssd_scan_ctrl_port_commit_ack <= 1'b0;
      ssd_scan_ctrl_port_frame_done <= 1'b0;
    end else begin
      ssd_scan_ctrl_port_code       <= code_s;
      ssd_scan_ctrl_port_dp         <= dp_s;
      ssd_scan_ctrl_port_an         <= an_s;
      ssd_scan_ctrl_port_commit_ack <= copy_s;
      ssd_scan_ctrl_port_frame_done <= boundary_s;
    end
  end

endmodule
